// File: rtl/uart_tx_sched.sv
// uart_tx_sched: queues J1 I/O writes to the UART TX address and
// drains them to buart one byte at a time, pacing on uart_busy.
module uart_tx_sched #(
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter logic [15:0] TX_ADDR      = 16'h0000,
   parameter logic [15:0] CLR_ADDR     = 16'h0002,
   parameter int unsigned RISE_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_wr,
   input  logic [15:0]           io_addr,
   input  logic [15:0]           io_dout,
   input  logic                  uart_busy,
   output logic                  uart_wr,
   output logic [7:0]            uart_tx_data,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_FULL = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] C_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE =
      {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [3:0] C_TMO = 4'(RISE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RISE,
      S_WAIT_FALL
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_timer;
   logic [3:0]            w_timer_nxt;
   logic                  r_wr;
   logic                  w_wr_nxt;
   logic                  w_load;
   logic [7:0]            r_tx_data;
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [DEPTH_LOG2:0]   w_count_nxt;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_ovf;
   logic                  w_push_req;
   logic                  w_clr;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_unused;

   // High byte of the write data is not part of the TX path.
   assign w_unused   = ^io_dout[15:8];

   assign w_push_req = io_wr && (io_addr == TX_ADDR);
   assign w_clr      = io_wr && (io_addr == CLR_ADDR);
   // ISSUE is only entered with a non-empty queue, so the pop is always legal.
   assign w_pop      = (r_state == S_ISSUE);
   // A pop in the same edge frees the slot a full-FIFO push needs.
   assign w_push     = w_push_req && (!r_full || w_pop);
   assign w_drop     = w_push_req && r_full && !w_pop;

   // Next occupancy from the push/pop pair of this edge.
   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO storage; contents need no reset since reads are gated by count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= io_dout[7:0];
      end
   end

   // Pointers, count, registered flags and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == C_FULL);
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Drain FSM: issue one byte, then wait for buart busy to rise and fall.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_wr_nxt    = 1'b0;
      w_load      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!r_empty && !uart_busy) begin
               w_state_nxt = S_ISSUE;
               w_wr_nxt    = 1'b1;
               w_load      = 1'b1;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT_RISE;
            w_timer_nxt = '0;
         end
         S_WAIT_RISE: begin
            if (uart_busy) begin
               w_state_nxt = S_WAIT_FALL;
            end else if (r_timer == C_TMO) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 4'd1;
            end
         end
         S_WAIT_FALL: begin
            if (!uart_busy) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state, rise timer, strobe and latched transmit byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_wr      <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_wr    <= w_wr_nxt;
         if (w_load) begin
            r_tx_data <= r_mem[r_rd_ptr];
         end
      end
   end

   assign uart_wr      = r_wr;
   assign uart_tx_data = r_tx_data;
   assign fifo_count   = r_count;
   assign fifo_empty   = r_empty;
   assign fifo_full    = r_full;
   assign overflow     = r_ovf;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a
// simple buart busy model driven from the falling clock edge.
module tb_uart_tx_sched;

   localparam logic [15:0] TX  = 16'h0000;
   localparam logic [15:0] CLR = 16'h0002;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_dout;
   logic        uart_busy;
   logic        uart_wr;
   logic [7:0]  uart_tx_data;
   logic [4:0]  fifo_count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic force_busy = 1'b0;
   logic model_en   = 1'b0;
   int   bcnt       = 0;
   int   busy_viol  = 0;
   logic [7:0] p_data [$];
   int         p_cyc  [$];

   uart_tx_sched dut (
      .clk          (clk),
      .reset        (reset),
      .io_wr        (io_wr),
      .io_addr      (io_addr),
      .io_dout      (io_dout),
      .uart_busy    (uart_busy),
      .uart_wr      (uart_wr),
      .uart_tx_data (uart_tx_data),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   assign uart_busy = force_busy | (bcnt != 0);

   // Cycle stamp for pulse spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse logger plus busy model: busy for 10 cycles after each strobe.
   always @(negedge clk) begin
      if (uart_wr) begin
         p_data.push_back(uart_tx_data);
         p_cyc.push_back(cyc);
         if (uart_busy) busy_viol++;
      end
      if (model_en && uart_wr) bcnt = 10;
      else if (bcnt != 0) bcnt--;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      io_wr   = 1'b1;
      io_addr = a;
      io_dout = d;
      @(negedge clk);
      io_wr   = 1'b0;
      io_dout = 16'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulses(input int n, input int maxc,
                              input string tag);
      int k;
      k = 0;
      while (p_data.size() < n && k < maxc) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(tag, p_data.size(), n);
   endtask

   initial begin
      reset   = 1'b1;
      io_wr   = 1'b0;
      io_addr = 16'hFFFF;
      io_dout = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_wr", uart_wr, 0);
      chk("rst_data", uart_tx_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      idle(2);

      // 1: single byte latency and pulse width
      model_en = 1'b1;
      wr(TX, 16'h1241);
      chk("t1_cnt1", fifo_count, 1);
      chk("t1_wr_early", uart_wr, 0);
      @(negedge clk);
      chk("t1_wr", uart_wr, 1);
      chk("t1_data", uart_tx_data, 8'h41);
      @(negedge clk);
      chk("t1_wr_width", uart_wr, 0);
      chk("t1_cnt0", fifo_count, 0);
      chk("t1_empty", fifo_empty, 1);
      idle(20);
      chk("t1_npulse", p_data.size(), 1);

      // 2: fill while busy, overflow and clear
      force_busy = 1'b1;
      idle(1);
      p_data.delete();
      p_cyc.delete();
      for (int i = 0; i < 16; i++) wr(TX, 16'(i));
      chk("t2_count", fifo_count, 16);
      chk("t2_full", fifo_full, 1);
      chk("t2_empty", fifo_empty, 0);
      chk("t2_ovf0", overflow, 0);
      wr(TX, 16'h00AA);
      chk("t2_ovf1", overflow, 1);
      chk("t2_count17", fifo_count, 16);
      wr(CLR, 16'h0);
      chk("t2_clr", overflow, 0);

      // 3: drain with responsive busy model
      force_busy = 1'b0;
      wait_pulses(16, 600, "t3_npulse");
      for (int i = 0; i < 16 && i < p_data.size(); i++)
         chk($sformatf("t3_data%0d", i), p_data[i], 8'(i));
      chk("t3_busy_viol", busy_viol, 0);
      idle(20);
      chk("t3_empty", fifo_empty, 1);
      chk("t3_count", fifo_count, 0);

      // 4: push coinciding with ISSUE pop while full
      force_busy = 1'b1;
      idle(1);
      p_data.delete();
      p_cyc.delete();
      for (int i = 0; i < 16; i++) wr(TX, 16'h10 + 16'(i));
      chk("t4_full", fifo_full, 1);
      force_busy = 1'b0;
      @(negedge clk);
      chk("t4_issue", uart_wr, 1);
      chk("t4_issue_data", uart_tx_data, 8'h10);
      wr(TX, 16'h0020);
      chk("t4_count", fifo_count, 16);
      chk("t4_ovf", overflow, 0);
      chk("t4_full2", fifo_full, 1);
      wait_pulses(17, 700, "t4_npulse");
      for (int i = 0; i < 17 && i < p_data.size(); i++)
         chk($sformatf("t4_data%0d", i), p_data[i], 8'h10 + 8'(i));
      chk("t4_busy_viol", busy_viol, 0);
      idle(20);
      chk("t4_empty", fifo_empty, 1);

      // 5: busy never rises, timeout pacing
      model_en = 1'b0;
      p_data.delete();
      p_cyc.delete();
      wr(TX, 16'h0051);
      wr(TX, 16'h0052);
      wr(TX, 16'h0053);
      wait_pulses(3, 100, "t5_npulse");
      if (p_data.size() >= 3) begin
         chk("t5_gap1", p_cyc[1] - p_cyc[0], 6);
         chk("t5_gap2", p_cyc[2] - p_cyc[1], 6);
         chk("t5_d0", p_data[0], 8'h51);
         chk("t5_d2", p_data[2], 8'h53);
      end
      idle(10);

      // 6: reset during WAIT_FALL with bytes queued
      model_en = 1'b1;
      p_data.delete();
      p_cyc.delete();
      for (int i = 0; i < 6; i++) wr(TX, 16'h60 + 16'(i));
      chk("t6_count5", fifo_count, 5);
      idle(1);
      reset = 1'b1;
      #1;
      chk("t6_rst_wr", uart_wr, 0);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_empty", fifo_empty, 1);
      idle(2);
      reset = 1'b0;
      chk("t6_one_pulse", p_data.size(), 1);
      idle(40);
      chk("t6_no_more", p_data.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
